// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline types: datapath widths, ALU op encoding, ID/EX control bundle.
package riscv_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_LUI  = 4'd10,
    ALU_PASS = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    alu_op_e alu_op;
    logic    branch;
    logic    jump;
  } id_ex_ctrl_t;

  // What the ID/EX register does at the next edge once reset is excluded.
  typedef enum logic [1:0] {
    ACT_CAPTURE,
    ACT_FLUSH,
    ACT_HOLD,
    ACT_BUBBLE
  } ex_action_e;

  function automatic logic reg_matches(input logic                      uses,
                                       input logic [REG_ADDR_WIDTH-1:0] src,
                                       input logic [REG_ADDR_WIDTH-1:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/id_ex_reg_load_use_detect.sv
// Load-use hazard term: EX holds a load writing a non-x0 register that the ID instruction reads.
module load_use_detect
  import riscv_pkg::*;
(
  input  logic                      ex_valid,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  input  logic                      id_valid,
  input  logic                      id_uses_rs1,
  input  logic                      id_uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  output logic                      load_use_hazard
);

  logic ex_is_load;
  logic src_match;

  always_comb begin
    ex_is_load      = ex_valid & ex_mem_read & (ex_rd_addr != '0);
    src_match       = reg_matches(id_uses_rs1, id_rs1_addr, ex_rd_addr) |
                      reg_matches(id_uses_rs2, id_rs2_addr, ex_rd_addr);
    load_use_hazard = ex_is_load & id_valid & src_match;
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion, EX flush and MEM backpressure.
// Optional saturating perf counters when ID_EX_PERF_EN is defined.
module id_ex_reg
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [XLEN-1:0]           id_pc,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                      id_uses_rs1,
  input  logic                      id_uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
  input  logic [XLEN-1:0]           id_rs1_data,
  input  logic [XLEN-1:0]           id_rs2_data,
  input  logic [XLEN-1:0]           id_imm,
  input  id_ex_ctrl_t               id_ctrl,
  input  logic                      ex_flush,
  input  logic                      mem_stall,
  output logic                      ex_valid,
  output logic [XLEN-1:0]           ex_pc,
  output logic [XLEN-1:0]           ex_rs1_data,
  output logic [XLEN-1:0]           ex_rs2_data,
  output logic [XLEN-1:0]           ex_imm,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs1_addr,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs2_addr,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  output id_ex_ctrl_t               ex_ctrl,
  output logic                      id_stall,
`ifdef ID_EX_PERF_EN
  output logic [31:0]               perf_bubbles,
  output logic [31:0]               perf_flushes,
`endif
  output logic                      load_use_hazard
);

  logic                      valid_q,    valid_d;
  logic [XLEN-1:0]           pc_q,       pc_d;
  logic [XLEN-1:0]           rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]           rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]           imm_q,      imm_d;
  logic [REG_ADDR_WIDTH-1:0] rs1_addr_q, rs1_addr_d;
  logic [REG_ADDR_WIDTH-1:0] rs2_addr_q, rs2_addr_d;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_q,  rd_addr_d;
  id_ex_ctrl_t               ctrl_q,     ctrl_d;

  logic       hazard_raw;
  ex_action_e act;

  load_use_detect u_load_use_detect (
    .ex_valid        (valid_q),
    .ex_mem_read     (ctrl_q.mem_read),
    .ex_rd_addr      (rd_addr_q),
    .id_valid        (id_valid),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .load_use_hazard (hazard_raw)
  );

  // Flush outranks the stall sources so a redirect is never held off.
  always_comb begin
    act = ACT_CAPTURE;
    if (ex_flush) begin
      act = ACT_FLUSH;
    end else if (mem_stall) begin
      act = ACT_HOLD;
    end else if (hazard_raw) begin
      act = ACT_BUBBLE;
    end
  end

  always_comb begin
    load_use_hazard = hazard_raw & ~rst;
    id_stall        = (hazard_raw | mem_stall) & ~ex_flush & ~rst;
  end

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rd_addr_d  = rd_addr_q;
    ctrl_d     = ctrl_q;
    unique case (act)
      ACT_FLUSH, ACT_BUBBLE: begin
        // Zeroed indices keep a bubble invisible to the forwarding network.
        valid_d    = 1'b0;
        ctrl_d     = '0;
        rs1_addr_d = '0;
        rs2_addr_d = '0;
        rd_addr_d  = '0;
      end
      ACT_HOLD: begin
      end
      ACT_CAPTURE: begin
        valid_d    = id_valid;
        pc_d       = id_pc;
        rs1_data_d = id_rs1_data;
        rs2_data_d = id_rs2_data;
        imm_d      = id_imm;
        ctrl_d     = id_valid ? id_ctrl     : '0;
        rs1_addr_d = id_valid ? id_rs1_addr : '0;
        rs2_addr_d = id_valid ? id_rs2_addr : '0;
        rd_addr_d  = id_valid ? id_rd_addr  : '0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= RESET_PC;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
      ctrl_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rd_addr_q  <= rd_addr_d;
      ctrl_q     <= ctrl_d;
    end
  end

  always_comb begin
    ex_valid    = valid_q;
    ex_pc       = pc_q;
    ex_rs1_data = rs1_data_q;
    ex_rs2_data = rs2_data_q;
    ex_imm      = imm_q;
    ex_rs1_addr = rs1_addr_q;
    ex_rs2_addr = rs2_addr_q;
    ex_rd_addr  = rd_addr_q;
    ex_ctrl     = ctrl_q;
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] bubbles_q, bubbles_d;
  logic [31:0] flushes_q, flushes_d;

  always_comb begin
    bubbles_d = bubbles_q;
    flushes_d = flushes_q;
    if ((act == ACT_BUBBLE) && (bubbles_q != '1)) begin
      bubbles_d = bubbles_q + 32'd1;
    end
    if ((act == ACT_FLUSH) && valid_q && (flushes_q != '1)) begin
      flushes_d = flushes_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubbles_q <= '0;
      flushes_q <= '0;
    end else begin
      bubbles_q <= bubbles_d;
      flushes_q <= flushes_d;
    end
  end

  always_comb begin
    perf_bubbles = bubbles_q;
    perf_flushes = flushes_q;
  end
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed test-plan steps followed by random traffic against a pipeline-slot model.
module tb_id_ex_reg;
  import riscv_pkg::*;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_1000;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      id_valid;
  logic [31:0]               id_pc;
  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic                      id_uses_rs1, id_uses_rs2;
  logic [31:0]               id_rs1_data, id_rs2_data, id_imm;
  id_ex_ctrl_t               id_ctrl;
  logic                      ex_flush, mem_stall;
  logic                      ex_valid;
  logic [31:0]               ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [REG_ADDR_WIDTH-1:0] ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  id_ex_ctrl_t               ex_ctrl;
  logic                      id_stall, load_use_hazard;

  id_ex_reg #(.XLEN(32), .RESET_PC(TB_RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_pc           (id_pc),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .id_rd_addr      (id_rd_addr),
    .id_rs1_data     (id_rs1_data),
    .id_rs2_data     (id_rs2_data),
    .id_imm          (id_imm),
    .id_ctrl         (id_ctrl),
    .ex_flush        (ex_flush),
    .mem_stall       (mem_stall),
    .ex_valid        (ex_valid),
    .ex_pc           (ex_pc),
    .ex_rs1_data     (ex_rs1_data),
    .ex_rs2_data     (ex_rs2_data),
    .ex_imm          (ex_imm),
    .ex_rs1_addr     (ex_rs1_addr),
    .ex_rs2_addr     (ex_rs2_addr),
    .ex_rd_addr      (ex_rd_addr),
    .ex_ctrl         (ex_ctrl),
    .id_stall        (id_stall),
    .load_use_hazard (load_use_hazard)
  );

  always #5 clk = ~clk;

  // Reference model of the EX slot contents.
  typedef struct {
    bit          valid;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  a1, a2, rd;
    id_ex_ctrl_t ctrl;
  } slot_t;

  slot_t       m;
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  bit          exp_haz, exp_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic id_ex_ctrl_t mk_ctrl(input bit rw, input bit mr, input alu_op_e op);
    id_ex_ctrl_t c;
    c            = '0;
    c.reg_write  = rw;
    c.mem_read   = mr;
    c.mem_to_reg = mr;
    c.alu_src    = mr;
    c.alu_op     = op;
    return c;
  endfunction

  task automatic set_id(input bit v, input logic [31:0] pc, input logic [4:0] r1, input bit u1,
                        input logic [4:0] r2, input bit u2, input logic [4:0] rd,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                        input id_ex_ctrl_t c);
    id_valid = v;  id_pc = pc;
    id_rs1_addr = r1; id_uses_rs1 = u1;
    id_rs2_addr = r2; id_uses_rs2 = u2;
    id_rd_addr = rd;  id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    id_ctrl = c;
  endtask

  task automatic rand_id();
    logic [$bits(id_ex_ctrl_t)-1:0] cbits;
    cbits = $bits(id_ex_ctrl_t)'($urandom);
    set_id(($urandom % 8) != 0, $urandom, 5'($urandom_range(0, 7)), 1'($urandom),
           5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
           $urandom, $urandom, $urandom, cbits);
  endtask

  // Settle inputs, then check the combinational outputs against the model.
  task automatic comb_phase();
    bit raw;
    #1;
    raw = m.valid && m.ctrl.mem_read && (m.rd != 0) && id_valid &&
          ((id_uses_rs1 && id_rs1_addr == m.rd) || (id_uses_rs2 && id_rs2_addr == m.rd));
    exp_haz   = !rst && raw;
    exp_stall = !rst && !ex_flush && (raw || mem_stall);
    chk("load_use_hazard", 64'(load_use_hazard), 64'(exp_haz));
    chk("id_stall", 64'(id_stall), 64'(exp_stall));
  endtask

  // Advance one edge, update the model by priority, check every registered output.
  task automatic edge_phase();
    bit raw;
    raw = m.valid && m.ctrl.mem_read && (m.rd != 0) && id_valid &&
          ((id_uses_rs1 && id_rs1_addr == m.rd) || (id_uses_rs2 && id_rs2_addr == m.rd));
    @(posedge clk);
    if (rst) begin
      m = '{valid: 0, pc: TB_RESET_PC, d1: 0, d2: 0, imm: 0, a1: 0, a2: 0, rd: 0, ctrl: '0};
    end else if (ex_flush || (!mem_stall && raw)) begin
      m.valid = 0; m.ctrl = '0; m.a1 = 0; m.a2 = 0; m.rd = 0;
    end else if (!mem_stall) begin
      m.valid = id_valid; m.pc = id_pc; m.d1 = id_rs1_data; m.d2 = id_rs2_data; m.imm = id_imm;
      m.ctrl = id_valid ? id_ctrl : '0;
      m.a1 = id_valid ? id_rs1_addr : 5'd0;
      m.a2 = id_valid ? id_rs2_addr : 5'd0;
      m.rd = id_valid ? id_rd_addr : 5'd0;
    end
    #1;
    chk("ex_valid", 64'(ex_valid), 64'(m.valid));
    chk("ex_pc", 64'(ex_pc), 64'(m.pc));
    chk("ex_rs1_data", 64'(ex_rs1_data), 64'(m.d1));
    chk("ex_rs2_data", 64'(ex_rs2_data), 64'(m.d2));
    chk("ex_imm", 64'(ex_imm), 64'(m.imm));
    chk("ex_rs1_addr", 64'(ex_rs1_addr), 64'(m.a1));
    chk("ex_rs2_addr", 64'(ex_rs2_addr), 64'(m.a2));
    chk("ex_rd_addr", 64'(ex_rd_addr), 64'(m.rd));
    chk("ex_ctrl", 64'(ex_ctrl), 64'(m.ctrl));
  endtask

  task automatic cycle();
    comb_phase();
    edge_phase();
  endtask

  initial begin
    id_ex_ctrl_t c_add, c_lw, c_lui;
    logic [31:0] held_pc;
    c_add = mk_ctrl(1, 0, ALU_ADD);
    c_lw  = mk_ctrl(1, 1, ALU_ADD);
    c_lui = mk_ctrl(1, 0, ALU_LUI);
    m = '{valid: 0, pc: 'x, d1: 'x, d2: 'x, imm: 'x, a1: 'x, a2: 'x, rd: 'x, ctrl: 'x};
    ex_flush = 0; mem_stall = 0;

    // Reset with a valid ID instruction present
    rst = 1;
    set_id(1, 32'h40, 5'd1, 1, 5'd2, 1, 5'd3, 32'd1, 32'd2, 32'd0, c_lw);
    cycle();
    cycle();
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_ex_ctrl", 64'(ex_ctrl), 64'd0);
    chk("rst_ex_pc", 64'(ex_pc), 64'(TB_RESET_PC));
    chk("rst_id_stall", 64'(id_stall), 64'd0);

    // ADD x3,x1,x2
    rst = 0;
    set_id(1, 32'h100, 5'd1, 1, 5'd2, 1, 5'd3, 32'd5, 32'd7, 32'd0, c_add);
    cycle();
    chk("add_rs1_addr", 64'(ex_rs1_addr), 64'd1);
    chk("add_rs2_addr", 64'(ex_rs2_addr), 64'd2);
    chk("add_rd_addr", 64'(ex_rd_addr), 64'd3);
    chk("add_rs1_data", 64'(ex_rs1_data), 64'd5);
    chk("add_ex_valid", 64'(ex_valid), 64'd1);

    // LW x5 then ADD x6,x5,x1: one stall cycle, one bubble
    set_id(1, 32'h104, 5'd1, 1, 5'd0, 0, 5'd5, 32'd5, 32'd0, 32'd8, c_lw);
    cycle();
    set_id(1, 32'h108, 5'd5, 1, 5'd1, 1, 5'd6, 32'd9, 32'd5, 32'd0, c_add);
    comb_phase();
    chk("lu_id_stall", 64'(id_stall), 64'd1);
    edge_phase();
    chk("lu_bubble_valid", 64'(ex_valid), 64'd0);
    chk("lu_bubble_rd", 64'(ex_rd_addr), 64'd0);
    comb_phase();
    chk("lu_after_stall", 64'(id_stall), 64'd0);
    edge_phase();
    chk("lu_consumer_rd", 64'(ex_rd_addr), 64'd6);

    // LW x0 followed by a reader of x0
    set_id(1, 32'h10c, 5'd1, 1, 5'd0, 0, 5'd0, 32'd0, 32'd0, 32'd4, c_lw);
    cycle();
    set_id(1, 32'h110, 5'd0, 1, 5'd0, 1, 5'd7, 32'd0, 32'd0, 32'd0, c_add);
    comb_phase();
    chk("x0_no_stall", 64'(id_stall), 64'd0);
    edge_phase();

    // LW x5 followed by LUI x6 whose rs1 field happens to be 5
    set_id(1, 32'h114, 5'd1, 1, 5'd0, 0, 5'd5, 32'd0, 32'd0, 32'd4, c_lw);
    cycle();
    set_id(1, 32'h118, 5'd5, 0, 5'd0, 0, 5'd6, 32'd0, 32'd0, 32'h5000, c_lui);
    comb_phase();
    chk("lui_no_stall", 64'(id_stall), 64'd0);
    chk("lui_no_hazard", 64'(load_use_hazard), 64'd0);
    edge_phase();

    // Flush together with a load-use condition
    set_id(1, 32'h11c, 5'd1, 1, 5'd0, 0, 5'd5, 32'd0, 32'd0, 32'd4, c_lw);
    cycle();
    set_id(1, 32'h120, 5'd5, 1, 5'd1, 1, 5'd6, 32'd0, 32'd0, 32'd0, c_add);
    ex_flush = 1;
    comb_phase();
    chk("flush_hazard_seen", 64'(load_use_hazard), 64'd1);
    chk("flush_no_stall", 64'(id_stall), 64'd0);
    edge_phase();
    chk("flush_ex_valid", 64'(ex_valid), 64'd0);
    chk("flush_reg_write", 64'(ex_ctrl.reg_write), 64'd0);
    ex_flush = 0;

    // Backpressure for three cycles with ID changing underneath
    set_id(1, 32'h200, 5'd1, 1, 5'd2, 1, 5'd7, 32'd11, 32'd12, 32'd0, c_add);
    cycle();
    held_pc = ex_pc;
    mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 32'h300 + 32'(i * 4), 5'd3, 1, 5'd4, 1, 5'd9, $urandom, $urandom, 32'd0, c_add);
      comb_phase();
      chk("bp_id_stall", 64'(id_stall), 64'd1);
      edge_phase();
      chk("bp_hold_rd", 64'(ex_rd_addr), 64'd7);
      chk("bp_hold_pc", 64'(ex_pc), 64'h200);
    end
    mem_stall = 0;
    cycle();
    chk("bp_release_rd", 64'(ex_rd_addr), 64'd9);
    chk("bp_release_pc", 64'(ex_pc), 64'h308);

    // Random traffic, including mid-stream resets
    for (int i = 0; i < 600; i++) begin
      rand_id();
      if ($urandom % 2 == 0) id_ctrl.mem_read = 1'b1;
      ex_flush  = ($urandom % 10) == 0;
      mem_stall = ($urandom % 5) == 0;
      rst       = ($urandom % 40) == 0;
      cycle();
    end
    rst = 0; ex_flush = 0; mem_stall = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no_finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
